range_counter: RTL and testbench
================================

RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/bound/step width in bits (>=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  count enable (0 = stop, 1 = run).
REQ-005 dir  input  1  direction request (1 = up, 0 = down).
REQ-006 mode  input  2  00 WRAP, 01 SAT, 10 PINGPONG, 11 ONESHOT.
REQ-007 min_val  input  WIDTH  lower bound, inclusive.
REQ-008 max_val  input  WIDTH  upper bound, inclusive.
REQ-009 step  input  WIDTH  increment magnitude; 0 is treated as 1.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  load value.
REQ-012 cnt  output  WIDTH  registered count.
REQ-013 tc  output  1  registered terminal-count flag.
REQ-014 done  output  1  registered ONESHOT completion flag.
REQ-015 dir_out  output  1  registered effective direction.
REQ-016 cfg_err  output  1  combinational; high when min_val > max_val.

Function
REQ-017 Effective direction: dir input in WRAP/SAT/ONESHOT; internal dir_q in PINGPONG; dir_out shows it.
REQ-018 Priority per edge: rst > load > cfg_err hold > en step > hold.
REQ-019 Load: cnt <= load_val clamped to [min_val,max_val]; done <= 0; tc <= 0; dir_q <= dir.
REQ-020 cfg_err high: cnt, dir_q, done hold; tc <= 0; load still clamps to max_val.
REQ-021 At-bound: up and cnt >= max_val, or down and cnt <= min_val.
REQ-022 Boundary event E = en & ~cfg_err & ~done & at-bound; tc <= E every edge.
REQ-023 Normal step (en, not at-bound): up cnt <= min(cnt+step, max_val), down cnt <= max(cnt-step, min_val), computed in WIDTH+1 bits, no wrap through 0/2^WIDTH.
REQ-024 WRAP on E: cnt <= opposite bound (min_val going up, max_val going down).
REQ-025 SAT on E: cnt holds; tc stays high while en and at-bound.
REQ-026 PINGPONG on E: cnt holds one dwell cycle, dir_q inverts; next enabled step moves away.
REQ-027 ONESHOT on E: cnt holds, done <= 1; further en ignored until load or rst.
REQ-028 en low: cnt, dir_q, done hold; tc <= 0.
REQ-029 min_val == max_val: every enabled cycle is E; cnt stays at the bound in all modes.
REQ-030 Runtime bound change leaving cnt out of range: no forced correction; REQ-021/REQ-023 rules apply.
REQ-031 mode change takes effect next edge; done clears only by load/rst.

Reset
REQ-032 rst: cnt <= (dir ? min_val : max_val); dir_q <= dir; tc <= 0; done <= 0.
REQ-033 rst mid-operation overrides load/en same edge; no other state retained.

Structure
REQ-034 Package range_counter_pkg holds mode encodings (MODE_WRAP/SAT/PINGPONG/ONESHOT).
REQ-035 Sub-module range_counter_next: combinational next-value, at-bound and clamp logic; top holds registers and mode control.

Verification (WIDTH=8)
REQ-036 WRAP up, min 3, max 7, step 1, rst then en -> cnt 3,4,5,6,7,3; tc high only in cycle cnt=3 after wrap.
REQ-037 SAT down, min 10, max 20, step 4 -> cnt 20,16,12,10,10...; tc high from cycle after first 10 sample while en.
REQ-038 PINGPONG, min 0, max 5, step 2, dir 1 -> cnt 0,2,4,5,5,3,1,0,0,2; dir_out flips on each dwell.
REQ-039 ONESHOT up, min 0, max 3 -> 0,1,2,3,3 with done=1 held under en; load 1 -> cnt 1, done 0.
REQ-040 Range 0..20: load=1,en=1,load_val 50 -> cnt 20; rst same edge as load -> reset value wins.
REQ-041 min 9, max 4 -> cfg_err 1, cnt holds, tc 0; restore max 12 -> counting resumes.

Source files
------------

// File: rtl/range_counter_pkg.sv
// ---------------------------------------------------------------------------
// range_counter_pkg
// Shared definitions for the range_counter block.
//   mode_e : counting-mode encoding carried on the 2-bit mode input.
// ---------------------------------------------------------------------------
package range_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SAT      = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_ONESHOT  = 2'b11
   } mode_e;

endpackage

// File: rtl/range_counter_next.sv
// ---------------------------------------------------------------------------
// range_counter_next
// Combinational helper for range_counter: computes the bounded step value,
// the at-bound condition, the clamped load value and the config error.
// Ports:
//   i_cnt       current count
//   i_up        effective direction (1 = up)
//   i_min/i_max inclusive bounds
//   i_step      step magnitude (0 behaves as 1)
//   i_load_val  raw load value
//   o_at_bound  up and cnt >= max, or down and cnt <= min
//   o_cfg_err   min > max
//   o_step_val  next count for a normal (non-boundary) step
//   o_load_val  load value clamped into [min, max]
// ---------------------------------------------------------------------------
module range_counter_next
   import range_counter_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic [WIDTH-1:0] i_cnt,
   input  logic             i_up,
   input  logic [WIDTH-1:0] i_min,
   input  logic [WIDTH-1:0] i_max,
   input  logic [WIDTH-1:0] i_step,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_at_bound,
   output logic             o_cfg_err,
   output logic [WIDTH-1:0] o_step_val,
   output logic [WIDTH-1:0] o_load_val
);

   logic [WIDTH-1:0] w_step;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_lo_clamped;

   assign w_step = (i_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_step;

   // One extra bit so the sum cannot wrap past 2^WIDTH and the
   // difference exposes a borrow instead of wrapping past 0.
   assign w_sum  = {1'b0, i_cnt} + {1'b0, w_step};
   assign w_diff = {1'b0, i_cnt} - {1'b0, w_step};

   assign o_cfg_err  = (i_min > i_max);
   assign o_at_bound = i_up ? (i_cnt >= i_max) : (i_cnt <= i_min);

   always_comb begin
      o_step_val = i_cnt;
      if (i_up) begin
         o_step_val = (w_sum > {1'b0, i_max}) ? i_max : w_sum[WIDTH-1:0];
      end else begin
         o_step_val = (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < i_min))
                      ? i_min : w_diff[WIDTH-1:0];
      end
   end

   // Lower clamp first, then upper: with min > max this always yields max.
   assign w_lo_clamped = (i_load_val < i_min) ? i_min : i_load_val;
   assign o_load_val   = (w_lo_clamped > i_max) ? i_max : w_lo_clamped;

endmodule

// File: rtl/range_counter.sv
// ---------------------------------------------------------------------------
// range_counter
// Bounded up/down counter with WRAP, SAT, PINGPONG and ONESHOT modes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                count enable
//   dir               direction request (1 = up)
//   mode              00 WRAP, 01 SAT, 10 PINGPONG, 11 ONESHOT
//   min_val, max_val  inclusive bounds
//   step              step magnitude (0 behaves as 1)
//   load, load_val    synchronous load, value clamped into range
//   cnt               registered count
//   tc                registered terminal-count (boundary event) flag
//   done              registered ONESHOT completion flag
//   dir_out           registered effective direction
//   cfg_err           combinational, min_val > max_val
// ---------------------------------------------------------------------------
module range_counter
   import range_counter_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             done,
   output logic             dir_out,
   output logic             cfg_err
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_dir_q;
   logic             r_tc;
   logic             r_done;
   logic             r_dir_out;

   mode_e            w_mode;
   logic             w_up;
   logic             w_at_bound;
   logic             w_cfg_err;
   logic             w_event;
   logic [WIDTH-1:0] w_step_val;
   logic [WIDTH-1:0] w_load_val;

   assign w_mode = mode_e'(mode);

   // PINGPONG follows its own direction register; other modes follow dir.
   assign w_up = (w_mode == MODE_PINGPONG) ? r_dir_q : dir;

   range_counter_next #(.WIDTH(WIDTH)) u_next (
      .i_cnt      (r_cnt),
      .i_up       (w_up),
      .i_min      (min_val),
      .i_max      (max_val),
      .i_step     (step),
      .i_load_val (load_val),
      .o_at_bound (w_at_bound),
      .o_cfg_err  (w_cfg_err),
      .o_step_val (w_step_val),
      .o_load_val (w_load_val)
   );

   assign w_event = en & ~w_cfg_err & ~r_done & w_at_bound;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= dir ? min_val : max_val;
         r_dir_q   <= dir;
         r_tc      <= 1'b0;
         r_done    <= 1'b0;
         r_dir_out <= dir;
      end else if (load) begin
         r_cnt     <= w_load_val;
         r_dir_q   <= dir;
         r_tc      <= 1'b0;
         r_done    <= 1'b0;
         r_dir_out <= dir;
      end else if (w_cfg_err) begin
         r_tc      <= 1'b0;
         r_dir_out <= w_up;
      end else if (en && !r_done) begin
         r_tc      <= w_event;
         r_dir_out <= w_up;
         if (w_event) begin
            case (w_mode)
               MODE_WRAP:     r_cnt <= w_up ? min_val : max_val;
               MODE_SAT:      r_cnt <= r_cnt;
               MODE_PINGPONG: begin
                  // Dwell at the bound for this cycle, turn around for the next.
                  r_dir_q   <= ~r_dir_q;
                  r_dir_out <= ~r_dir_q;
               end
               MODE_ONESHOT:  r_done <= 1'b1;
               default:       r_cnt <= r_cnt;
            endcase
         end else begin
            r_cnt <= w_step_val;
         end
      end else begin
         r_tc      <= 1'b0;
         r_dir_out <= w_up;
      end
   end

   assign cnt     = r_cnt;
   assign tc      = r_tc;
   assign done    = r_done;
   assign dir_out = r_dir_out;
   assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_range_counter.sv
// ---------------------------------------------------------------------------
// tb_range_counter
// Self-checking bench for range_counter (WIDTH = 8): directed sequences with
// literal expectations, then randomized stimulus against a behavioural model.
// ---------------------------------------------------------------------------
module tb_range_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       dir;
   logic [1:0] mode;
   logic [7:0] min_val;
   logic [7:0] max_val;
   logic [7:0] step;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] cnt;
   logic       tc;
   logic       done;
   logic       dir_out;
   logic       cfg_err;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   bit m_valid = 0;
   int m_cnt   = 0;
   bit m_dirq  = 0;
   bit m_tc    = 0;
   bit m_done  = 0;
   bit m_dout  = 0;

   int wrap_c[5] = '{4, 5, 6, 7, 3};
   int wrap_t[5] = '{0, 0, 0, 0, 1};
   int sat_c[5]  = '{16, 12, 10, 10, 10};
   int sat_t[5]  = '{0, 0, 0, 1, 1};
   int pp_c[9]   = '{2, 4, 5, 5, 3, 1, 0, 0, 2};
   int pp_d[9]   = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
   int os_c[5]   = '{1, 2, 3, 3, 3};
   int os_d[5]   = '{0, 0, 0, 1, 1};

   range_counter #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .min_val  (min_val),
      .max_val  (max_val),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .cnt      (cnt),
      .tc       (tc),
      .done     (done),
      .dir_out  (dir_out),
      .cfg_err  (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: applies the counter rules to plain integers each edge.
   always @(posedge clk) begin : model
      int lo, hi, c, s, v;
      bit up, bnd;
      lo = int'(min_val);
      hi = int'(max_val);
      c  = m_cnt;
      s  = (step == 8'd0) ? 1 : int'(step);
      up = (mode == 2'b10) ? m_dirq : dir;
      if (rst) begin
         m_cnt   = dir ? lo : hi;
         m_dirq  = dir;
         m_tc    = 0;
         m_done  = 0;
         m_dout  = dir;
         m_valid = 1;
      end else if (load) begin
         v = int'(load_val);
         if (v < lo) v = lo;
         if (v > hi) v = hi;
         m_cnt  = v;
         m_dirq = dir;
         m_tc   = 0;
         m_done = 0;
         m_dout = dir;
      end else if (lo > hi) begin
         m_tc   = 0;
         m_dout = up;
      end else if (en && !m_done) begin
         bnd    = up ? (c >= hi) : (c <= lo);
         m_tc   = bnd;
         m_dout = up;
         if (!bnd) begin
            if (up) m_cnt = (c + s > hi) ? hi : c + s;
            else    m_cnt = (c - s < lo) ? lo : c - s;
         end else begin
            case (mode)
               2'b00: m_cnt = up ? lo : hi;
               2'b10: begin m_dirq = !m_dirq; m_dout = m_dirq; end
               2'b11: m_done = 1;
               default: ;
            endcase
         end
      end else begin
         m_tc   = 0;
         m_dout = up;
      end
   end

   // Compare process: checks every output against the model each cycle.
   always @(posedge clk) begin
      #2;
      if (m_valid) begin
         chk("cnt",     int'(cnt),     m_cnt);
         chk("tc",      int'(tc),      int'(m_tc));
         chk("done",    int'(done),    int'(m_done));
         chk("dir_out", int'(dir_out), int'(m_dout));
         chk("cfg_err", int'(cfg_err), int'(min_val > max_val));
      end
   end

   task automatic cyc;
      @(posedge clk);
      #3;
   endtask

   task automatic setup(input bit d, input logic [1:0] md,
                        input int mn, input int mx, input int st);
      rst      = 1'b1;
      load     = 1'b0;
      en       = 1'b0;
      dir      = d;
      mode     = md;
      min_val  = 8'(mn);
      max_val  = 8'(mx);
      step     = 8'(st);
      load_val = 8'd0;
   endtask

   function automatic logic [7:0] pick_bound();
      if ($urandom % 8 == 0) return 8'($urandom_range(200, 255));
      return 8'($urandom_range(0, 40));
   endfunction

   initial begin
      setup(1'b1, 2'b00, 3, 7, 1);

      // WRAP up 3..7
      cyc();
      chk("wrap_rst_cnt", int'(cnt), 3);
      chk("wrap_rst_tc", int'(tc), 0);
      chk("wrap_rst_done", int'(done), 0);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("wrap_cnt", int'(cnt), wrap_c[i]);
         chk("wrap_tc", int'(tc), wrap_t[i]);
      end

      // SAT down 10..20 step 4
      setup(1'b0, 2'b01, 10, 20, 4);
      cyc();
      chk("sat_rst_cnt", int'(cnt), 20);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("sat_cnt", int'(cnt), sat_c[i]);
         chk("sat_tc", int'(tc), sat_t[i]);
      end

      // PINGPONG 0..5 step 2
      setup(1'b1, 2'b10, 0, 5, 2);
      cyc();
      chk("pp_rst_cnt", int'(cnt), 0);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("pp_cnt", int'(cnt), pp_c[i]);
         chk("pp_dir_out", int'(dir_out), pp_d[i]);
      end

      // ONESHOT up 0..3, then reload
      setup(1'b1, 2'b11, 0, 3, 1);
      cyc();
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("os_cnt", int'(cnt), os_c[i]);
         chk("os_done", int'(done), os_d[i]);
      end
      load = 1'b1; load_val = 8'd1;
      cyc();
      chk("os_load_cnt", int'(cnt), 1);
      chk("os_load_done", int'(done), 0);

      // load clamp, then reset beating load on the same edge
      mode = 2'b00; min_val = 8'd0; max_val = 8'd20; load_val = 8'd50;
      cyc();
      chk("clamp_cnt", int'(cnt), 20);
      rst = 1'b1; load_val = 8'd10; dir = 1'b1;
      cyc();
      chk("rst_over_load", int'(cnt), 0);
      rst = 1'b0; load = 1'b0;

      // inverted bounds hold the count, then counting resumes
      min_val = 8'd9; max_val = 8'd4;
      #1;
      chk("cfg_err_hi", int'(cfg_err), 1);
      cyc();
      chk("cfg_hold_cnt", int'(cnt), 0);
      chk("cfg_hold_tc", int'(tc), 0);
      cyc();
      chk("cfg_hold_cnt2", int'(cnt), 0);
      max_val = 8'd12;
      #1;
      chk("cfg_err_lo", int'(cfg_err), 0);
      cyc();
      chk("resume_cnt", int'(cnt), 1);
      cyc();
      chk("resume_cnt2", int'(cnt), 2);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom % 64 == 0);
         load = ($urandom % 16 == 0);
         en   = ($urandom % 4 != 0);
         load_val = 8'($urandom);
         if ($urandom % 8 == 0)  dir  = ~dir;
         if ($urandom % 32 == 0) mode = 2'($urandom);
         if ($urandom % 32 == 0) begin
            min_val = pick_bound();
            max_val = pick_bound();
            if ($urandom % 3 != 0 && min_val > max_val) begin
               load_val = min_val; min_val = max_val; max_val = load_val;
            end
            if ($urandom % 8 == 0) max_val = min_val;
         end
         if ($urandom % 16 == 0)
            step = 8'($urandom);
         else if ($urandom % 8 == 0)
            step = 8'($urandom_range(0, 6));
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
